// File: rtl/puf_eval_sequencer.sv
// Sequences arbiter-PUF evaluations over an LFSR challenge walk and majority-votes each challenge's responses.
// Latency: 2*SETTLE_CYC+2 cycles per evaluation; a full run is NUM_CHAL*(NUM_EVAL*(2*SETTLE_CYC+2)+1)+1 cycles.
// Backpressure: none; start is only honoured in IDLE. Optional raw tap outputs are enabled with RAW_TAP_EN.
module puf_eval_sequencer #(
    parameter int CHAL_W     = 8,
    parameter int NUM_CHAL   = 8,
    parameter int NUM_EVAL   = 5,
    parameter int SETTLE_CYC = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CHAL_W-1:0]             seed,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_CHAL-1:0]           resp_word,
    output logic [$clog2(NUM_CHAL+1)-1:0] unstable_cnt,
    output logic [CHAL_W-1:0]             puf_challenge,
    output logic                          puf_pulse,
    input  logic                          puf_resp
`ifdef RAW_TAP_EN
    ,
    output logic                          raw_valid,
    output logic                          raw_bit
`endif
);

    localparam int UC_W = $clog2(NUM_CHAL + 1);
    localparam int CI_W = (NUM_CHAL > 1) ? $clog2(NUM_CHAL) : 1;
    localparam int EV_W = $clog2(NUM_EVAL + 1);
    localparam int PH_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0] PH_SMP   = PH_W'(1);
    localparam logic [EV_W-1:0] EV_LAST  = EV_W'(NUM_EVAL - 1);
    localparam logic [EV_W-1:0] EV_ALL   = EV_W'(NUM_EVAL);
    localparam logic [EV_W-1:0] EV_HALF  = EV_W'(NUM_EVAL / 2);
    localparam logic [CI_W-1:0] CI_LAST  = CI_W'(NUM_CHAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_FIRE,
        S_SAMPLE,
        S_VOTE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [EV_W-1:0]     eval_q, eval_d;
    logic [EV_W-1:0]     ones_q, ones_d;
    logic [CI_W-1:0]     chal_idx_q, chal_idx_d;
    logic [CHAL_W-1:0]   chal_q, chal_d;
    logic [NUM_CHAL-1:0] resp_q, resp_d;
    logic [UC_W-1:0]     unst_q, unst_d;
    logic                busy_q, done_q, pulse_q;
    logic [1:0]          sync_q;

    // Fibonacci LFSR step; the tap set assumes an 8-bit challenge.
    function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] c);
        return {c[CHAL_W-2:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
    endfunction

    // Next-state and datapath update; every register holds unless its state says otherwise.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        eval_d     = eval_q;
        ones_d     = ones_q;
        chal_idx_d = chal_idx_q;
        chal_d     = chal_q;
        resp_d     = resp_q;
        unst_d     = unst_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // An all-zero seed would lock the LFSR, so it is replaced by 1.
                    chal_d     = (seed == '0) ? CHAL_W'(1) : seed;
                    chal_idx_d = '0;
                    eval_d     = '0;
                    ones_d     = '0;
                    resp_d     = '0;
                    unst_d     = '0;
                    phase_d    = '0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = S_FIRE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_FIRE: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = S_SAMPLE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_SAMPLE: begin
                // Second cycle gives the synchronizer time to carry the arbiter decision.
                if (phase_q == PH_SMP) begin
                    phase_d = '0;
                    ones_d  = ones_q + EV_W'(sync_q[1]);
                    eval_d  = eval_q + EV_W'(1);
                    state_d = (eval_q == EV_LAST) ? S_VOTE : S_SETUP;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_VOTE: begin
                resp_d[chal_idx_q] = (ones_q > EV_HALF);
                if ((ones_q != '0) && (ones_q != EV_ALL)) begin
                    unst_d = unst_q + UC_W'(1);
                end
                ones_d = '0;
                eval_d = '0;
                if (chal_idx_q == CI_LAST) begin
                    state_d = S_DONE;
                end else begin
                    chal_idx_d = chal_idx_q + CI_W'(1);
                    chal_d     = lfsr_next(chal_q);
                    state_d    = S_SETUP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs are decoded from next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            eval_q     <= '0;
            ones_q     <= '0;
            chal_idx_q <= '0;
            chal_q     <= '0;
            resp_q     <= '0;
            unst_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            eval_q     <= eval_d;
            ones_q     <= ones_d;
            chal_idx_q <= chal_idx_d;
            chal_q     <= chal_d;
            resp_q     <= resp_d;
            unst_q     <= unst_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
            pulse_q    <= (state_d == S_FIRE);
        end
    end

    // Two-flop synchronizer for the asynchronous arbiter output; runs every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], puf_resp};
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign puf_pulse     = pulse_q;
    assign puf_challenge = chal_q;
    assign resp_word     = resp_q;
    assign unstable_cnt  = unst_q;

`ifdef RAW_TAP_EN
    // Raw tap exposes each synchronized sample on its capture cycle.
    always_comb begin
        raw_valid = (state_q == S_SAMPLE) && (phase_q == PH_SMP);
        raw_bit   = raw_valid & sync_q[1];
    end
`endif

endmodule

// File: tb/tb_puf_eval_sequencer.sv
module tb_puf_eval_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] seed;
    logic       busy;
    logic       done;
    logic [7:0] resp_word;
    logic [3:0] unstable_cnt;
    logic [7:0] puf_challenge;
    logic       puf_pulse;
    logic       puf_resp;
`ifdef RAW_TAP_EN
    logic       raw_valid;
    logic       raw_bit;
`endif

    puf_eval_sequencer #(
        .CHAL_W(8), .NUM_CHAL(8), .NUM_EVAL(5), .SETTLE_CYC(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .busy(busy), .done(done), .resp_word(resp_word),
        .unstable_cnt(unstable_cnt), .puf_challenge(puf_challenge),
        .puf_pulse(puf_pulse), .puf_resp(puf_resp)
`ifdef RAW_TAP_EN
        , .raw_valid(raw_valid), .raw_bit(raw_bit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // PUF model state: mode 0 parity, 1 ones on evals 0-1, 2 ones on evals 0-2, 3 constant one.
    int         mode = 0;
    int         run_id = 0;
    int         seen_run = 0;
    int         rises = 0;
    int         chg_err = 0;
    int         raw_cnt = 0;
    int         raw_bad = 0;
    logic [7:0] chal_log [8];
    logic [7:0] rise_chal = 8'h00;
    logic       pulse_prev = 1'b0;
    logic       apply_pend = 1'b0;
    logic       model_bit = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // PUF model and monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        int eidx;
        if (run_id != seen_run) begin
            seen_run = run_id;
            rises    = 0;
            chg_err  = 0;
            raw_cnt  = 0;
            raw_bad  = 0;
            for (int k = 0; k < 8; k++) chal_log[k] = 8'h00;
        end
        if (apply_pend) begin
            puf_resp   = model_bit;
            apply_pend = 1'b0;
        end
        if (puf_pulse && !pulse_prev) begin
            eidx = rises % 5;
            if (eidx == 0 && rises / 5 < 8) chal_log[rises / 5] = puf_challenge;
            case (mode)
                0:       model_bit = ^puf_challenge;
                1:       model_bit = (eidx < 2);
                2:       model_bit = (eidx < 3);
                default: model_bit = 1'b1;
            endcase
            apply_pend = 1'b1;
            rise_chal  = puf_challenge;
            rises++;
        end
        if (puf_pulse && pulse_prev && puf_challenge !== rise_chal) chg_err++;
        pulse_prev = puf_pulse;
`ifdef RAW_TAP_EN
        if (raw_valid === 1'b1) begin
            raw_cnt++;
            if (raw_bit !== 1'b1) raw_bad++;
        end
`endif
    end

    // Launches a run and waits (bounded) for done; optionally pokes start mid-run with a junk seed.
    task automatic do_run(input logic [7:0] s, input int m, input bit inj, output int cyc);
        mode = m;
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        run_id++;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        chk("busy_after_accept", busy, 1);
        while (done !== 1'b1 && cyc < 1000) begin
            if (inj && (cyc == 49 || cyc == 199)) begin
                start = 1'b1;
                seed  = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    int cyc;
    int pulse_hi;
    logic [7:0] exp_chal [8];

    initial begin
        exp_chal = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
        rst = 1'b1; start = 1'b0; seed = 8'h00; puf_resp = 1'b0;

        // Reset and idle behaviour.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pulse", puf_pulse, 0);
        chk("rst_resp", resp_word, 8'h00);
        chk("rst_unst", unstable_cnt, 0);
        chk("rst_chal", puf_challenge, 8'h00);
        rst = 1'b0;
        pulse_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (puf_pulse !== 1'b0 || busy !== 1'b0) pulse_hi++;
        end
        chk("idle_quiet", pulse_hi, 0);

        // Parity model, seed 0x01.
        do_run(8'h01, 0, 1'b0, cyc);
        chk("p1_cycles", cyc, 409);
        chk("p1_resp", resp_word, 8'h2F);
        chk("p1_unst", unstable_cnt, 0);
        @(negedge clk);
        chk("p1_done_width", done, 0);
        chk("p1_busy_end", busy, 0);
        chk("p1_rises", rises, 40);
        chk("p1_chal_stable", chg_err, 0);
        for (int k = 0; k < 8; k++) chk("p1_chal_seq", chal_log[k], exp_chal[k]);
        repeat (10) @(negedge clk);
        chk("p1_hold_resp", resp_word, 8'h2F);
        chk("p1_hold_unst", unstable_cnt, 0);
        chk("p1_hold_pulse", puf_pulse, 0);

        // Zero seed is remapped to 0x01.
        do_run(8'h00, 0, 1'b0, cyc);
        chk("p0_cycles", cyc, 409);
        chk("p0_resp", resp_word, 8'h2F);
        chk("p0_unst", unstable_cnt, 0);
        chk("p0_first_chal", chal_log[0], 8'h01);
        chk("p0_last_chal", chal_log[7], 8'h8E);

        // Noisy models: 2 of 5 ones votes 0, 3 of 5 votes 1; both unstable everywhere.
        do_run(8'h01, 1, 1'b0, cyc);
        chk("n2_resp", resp_word, 8'h00);
        chk("n2_unst", unstable_cnt, 8);
        do_run(8'h01, 2, 1'b0, cyc);
        chk("n3_resp", resp_word, 8'hFF);
        chk("n3_unst", unstable_cnt, 8);

        // Start pulses mid-run are ignored.
        do_run(8'h01, 0, 1'b1, cyc);
        chk("ign_cycles", cyc, 409);
        chk("ign_resp", resp_word, 8'h2F);
        chk("ign_unst", unstable_cnt, 0);
        chk("ign_first_chal", chal_log[0], 8'h01);
        @(negedge clk);
        chk("ign_idle_after", busy, 0);

        // Reset at cycle 100 of a run discards everything.
        mode = 0;
        @(negedge clk);
        seed = 8'h01; start = 1'b1; run_id++;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        chk("mid_resp_partial", resp_word, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pulse", puf_pulse, 0);
        chk("mid_rst_resp", resp_word, 8'h00);
        chk("mid_rst_chal", puf_challenge, 8'h00);
        rst = 1'b0;
        do_run(8'h01, 0, 1'b0, cyc);
        chk("mid_fresh_cycles", cyc, 409);
        chk("mid_fresh_resp", resp_word, 8'h2F);
        chk("mid_fresh_unst", unstable_cnt, 0);

`ifdef RAW_TAP_EN
        do_run(8'h01, 3, 1'b0, cyc);
        @(negedge clk);
        chk("raw_count", raw_cnt, 40);
        chk("raw_bits", raw_bad, 0);
        chk("raw_resp", resp_word, 8'hFF);
        chk("raw_unst", unstable_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish, required finish within 2000000 time units");
        $fatal(1, "timeout");
    end

endmodule
